// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states,
// register-zero constant, decode opcodes and the load-use hazard test.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Decode helpers: the 11xx control-flow group reads no Rs except BR.
  function automatic logic op_uses_rs(input logic [3:0] op);
    return (op == OP_BR) || (op[3:2] != 2'b11);
  endfunction

  // Rt is read by the ALU group and as store data; loads write it instead.
  function automatic logic op_uses_rt(input logic [3:0] op);
    return (op != OP_LW) && ((op[3] == 1'b0) || (op == OP_SW));
  endfunction

  function automatic logic load_use_hazard(
    input logic       memread,
    input logic [3:0] regrd,
    input logic [3:0] rs,
    input logic [3:0] rt,
    input logic       uses_rs,
    input logic       uses_rt
  );
    return memread && (regrd != REG_ZERO) &&
           ((uses_rs && (rs == regrd)) || (uses_rt && (rt == regrd)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the hazard controller (master) and the pipeline
// registers it steers (slave); also carries FSM debug visibility.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  import hazard_stall_ctrl_pkg::*;

  logic [3:0]       id_rs;
  logic [3:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             idex_memread;
  logic [3:0]       idex_regrd;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt_wb;

  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_flush;
  logic             idex_wen;
  logic             idex_flush;
  logic             exmem_wen;
  logic             exmem_flush;
  logic             memwb_wen;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  state_t           state_dbg;
  logic             br_pending_dbg;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_memread, idex_regrd,
           branch_taken, mem_busy, halt_wb,
    output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
           exmem_flush, memwb_wen, halted, stall_cnt, flush_cnt,
           state_dbg, br_pending_dbg
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_memread, idex_regrd,
           branch_taken, mem_busy, halt_wb,
    input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
           exmem_flush, memwb_wen, halted, stall_cnt, flush_cnt,
           state_dbg, br_pending_dbg
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes,
// data-memory wait freezing with deferred branch flush, and halt.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int BR_FLUSH_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.master  bus
);

  localparam logic EX_FLUSH_ON_BR = (BR_FLUSH_DEPTH == 3);

  state_t state_q, state_d;
  logic   br_pending_q, br_pending_d;
  logic   wen_all, lu_bubble, br_flush, is_halted;
  logic   stall_inc, flush_inc, load_use;

  assign load_use = load_use_hazard(bus.idex_memread, bus.idex_regrd,
                                    bus.id_rs, bus.id_rt,
                                    bus.id_uses_rs, bus.id_uses_rt);

  always_comb begin
    state_d      = state_q;
    br_pending_d = br_pending_q;
    wen_all      = 1'b0;
    lu_bubble    = 1'b0;
    br_flush     = 1'b0;
    is_halted    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.halt_wb) begin
          state_d   = HALT;
          stall_inc = 1'b1;
        end else if (bus.mem_busy) begin
          br_pending_d = bus.branch_taken;
          state_d      = MEMWAIT;
          stall_inc    = 1'b1;
        end else if (bus.branch_taken) begin
          // The flush kills the dependent instruction, so no bubble is needed.
          wen_all   = 1'b1;
          br_flush  = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          wen_all   = 1'b1;
          lu_bubble = 1'b1;
          stall_inc = 1'b1;
        end else begin
          wen_all = 1'b1;
        end
      end
      MEMWAIT: begin
        if (bus.mem_busy) begin
          br_pending_d = br_pending_q | bus.branch_taken;
          stall_inc    = 1'b1;
        end else begin
          // Release cycle: load-use waits for the following RUN cycle.
          wen_all      = 1'b1;
          br_flush     = br_pending_q;
          flush_inc    = br_pending_q;
          br_pending_d = 1'b0;
          state_d      = RUN;
        end
      end
      HALT: begin
        is_halted = 1'b1;
      end
      default: begin
        state_d      = RUN;
        br_pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      br_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      br_pending_q <= br_pending_d;
    end
  end

  // Every control output is forced low while reset is held.
  always_comb begin
    bus.pc_wen      = rst_n & wen_all & ~lu_bubble;
    bus.ifid_wen    = rst_n & wen_all & ~lu_bubble;
    bus.idex_wen    = rst_n & wen_all;
    bus.exmem_wen   = rst_n & wen_all;
    bus.memwb_wen   = rst_n & wen_all;
    bus.ifid_flush  = rst_n & br_flush;
    bus.idex_flush  = rst_n & (br_flush | lu_bubble);
    bus.exmem_flush = rst_n & br_flush & EX_FLUSH_ON_BR;
    bus.halted      = rst_n & is_halted;
  end

  assign bus.state_dbg      = state_q;
  assign bus.br_pending_dbg = br_pending_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table plus hand-written multi-cycle
// sequences, checked through an expected-value queue on the falling edge.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 18;

  // control bits: pc, ifid_wen, ifid_fl, idex_wen, idex_fl, exmem_wen, exmem_fl, memwb, halted
  localparam logic [8:0] C_ALL    = 9'b110101010;
  localparam logic [8:0] C_LU     = 9'b000111010;
  localparam logic [8:0] C_BR3    = 9'b111111110;
  localparam logic [8:0] C_FROZEN = 9'b000000000;
  localparam logic [8:0] C_HALTED = 9'b000000001;

  typedef struct packed {
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       mrd;
    logic [3:0] rd;
    logic       br;
    logic       busy;
    logic       hlt;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [8:0] ctrl;
    logic [3:0] stall;
    logic [3:0] flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus3 ();
  hazard_stall_ctrl_if #(.CNT_W(16))    bus2 ();

  hazard_stall_ctrl #(.CNT_W(CNT_W), .BR_FLUSH_DEPTH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  hazard_stall_ctrl #(.CNT_W(16), .BR_FLUSH_DEPTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_exp, sb_act;
  string        sb_tag;
  vec_t         vecs[15];
  in_t          idle, busy_in, busy_br, hlt_in, lu_in;

  function automatic in_t mk(input logic [3:0] rs, input logic [3:0] rt,
                             input logic urs, input logic urt, input logic mrd,
                             input logic [3:0] rd, input logic br,
                             input logic busy, input logic hlt);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd;
    v.rd = rd; v.br = br; v.busy = busy; v.hlt = hlt;
    return v;
  endfunction

  // dut2 (two-stage branch flush) contributes its exmem_flush as the top bit.
  function automatic logic [W-1:0] actual();
    return {bus2.exmem_flush, bus3.pc_wen, bus3.ifid_wen, bus3.ifid_flush,
            bus3.idex_wen, bus3.idex_flush, bus3.exmem_wen, bus3.exmem_flush,
            bus3.memwb_wen, bus3.halted, bus3.stall_cnt, bus3.flush_cnt};
  endfunction

  task automatic drive(input in_t v);
    bus3.id_rs = v.rs;  bus3.id_rt = v.rt;  bus3.id_uses_rs = v.urs;
    bus3.id_uses_rt = v.urt; bus3.idex_memread = v.mrd; bus3.idex_regrd = v.rd;
    bus3.branch_taken = v.br; bus3.mem_busy = v.busy; bus3.halt_wb = v.hlt;
    bus2.id_rs = v.rs;  bus2.id_rt = v.rt;  bus2.id_uses_rs = v.urs;
    bus2.id_uses_rt = v.urt; bus2.idex_memread = v.mrd; bus2.idex_regrd = v.rd;
    bus2.branch_taken = v.br; bus2.mem_busy = v.busy; bus2.halt_wb = v.hlt;
  endtask

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, expectation checked at the falling edge.
  task automatic step(input in_t v, input logic [8:0] ctrl,
                      input logic [3:0] s, input logic [3:0] f, input string tag);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back({1'b0, ctrl, s, f});
    tag_q.push_back(tag);
  endtask

  // Drops reset between edges and checks that everything clears at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    check({tag, "_outputs"}, actual(), '0);
    check({tag, "_state"}, W'({bus3.state_dbg, bus3.br_pending_dbg}),
          W'({RUN, 1'b0}));
    drive(idle);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_tag = tag_q.pop_front();
      sb_act = actual();
      check(sb_tag, sb_act, sb_exp);
    end
  end

  initial begin
    idle    = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    busy_in = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    busy_br = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    hlt_in  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    lu_in   = mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);

    vecs[0]  = '{idle, C_ALL, 4'd0, 4'd0};
    vecs[1]  = '{lu_in, C_LU, 4'd0, 4'd0};
    vecs[2]  = '{mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0), C_ALL, 4'd1, 4'd0};
    vecs[3]  = '{mk(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), C_ALL, 4'd1, 4'd0};
    vecs[4]  = '{mk(4'd3, 4'd7, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0), C_LU, 4'd1, 4'd0};
    vecs[5]  = '{mk(4'd3, 4'd7, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0), C_ALL, 4'd2, 4'd0};
    vecs[6]  = '{mk(4'd9, 4'd4, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0), C_ALL, 4'd2, 4'd0};
    vecs[7]  = '{mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), C_BR3, 4'd2, 4'd0};
    vecs[8]  = '{mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0), C_BR3, 4'd2, 4'd1};
    vecs[9]  = '{idle, C_ALL, 4'd2, 4'd2};
    vecs[10] = '{busy_in, C_FROZEN, 4'd2, 4'd2};
    vecs[11] = '{busy_in, C_FROZEN, 4'd3, 4'd2};
    vecs[12] = '{lu_in, C_ALL, 4'd4, 4'd2};
    vecs[13] = '{lu_in, C_LU, 4'd4, 4'd2};
    vecs[14] = '{idle, C_ALL, 4'd5, 4'd2};

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", actual(), '0);
    check("reset_state", W'({bus3.state_dbg, bus3.br_pending_dbg}), W'({RUN, 1'b0}));
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) step(vecs[i].in, vecs[i].ctrl, vecs[i].stall,
                                      vecs[i].flush, $sformatf("vec%0d", i));

    // Memory wait of four cycles with a branch resolving on the second.
    do_reset("rst_a");
    step(busy_in, C_FROZEN, 4'd0, 4'd0, "mw_c1");
    step(busy_br, C_FROZEN, 4'd1, 4'd0, "mw_c2");
    step(busy_in, C_FROZEN, 4'd2, 4'd0, "mw_c3");
    step(busy_in, C_FROZEN, 4'd3, 4'd0, "mw_c4");
    step(idle, C_BR3, 4'd4, 4'd0, "mw_release");
    step(idle, C_ALL, 4'd4, 4'd1, "mw_after");
    // Branch seen in the same RUN cycle the wait begins.
    step(busy_br, C_FROZEN, 4'd4, 4'd1, "mwb_c1");
    step(idle, C_BR3, 4'd5, 4'd1, "mwb_release");
    step(idle, C_ALL, 4'd5, 4'd2, "mwb_after");

    // Reset during a wait must forget the pending branch.
    do_reset("rst_b");
    step(busy_br, C_FROZEN, 4'd0, 4'd0, "rmw_c1");
    step(busy_in, C_FROZEN, 4'd1, 4'd0, "rmw_c2");
    do_reset("rst_mw");
    step(idle, C_ALL, 4'd0, 4'd0, "rmw_after1");
    step(idle, C_ALL, 4'd0, 4'd0, "rmw_after2");

    // Stall counter saturation with a 4-bit counter.
    do_reset("rst_c");
    for (int k = 0; k < 19; k++)
      step(busy_in, C_FROZEN, (k > 15) ? 4'd15 : 4'(k), 4'd0, $sformatf("sat%0d", k));
    step(idle, C_ALL, 4'd15, 4'd0, "sat_release");
    step(idle, C_ALL, 4'd15, 4'd0, "sat_hold");

    // Halt freezes everything until reset.
    do_reset("rst_d");
    step(hlt_in, C_FROZEN, 4'd0, 4'd0, "halt_entry");
    step(idle, C_HALTED, 4'd1, 4'd0, "halt_1");
    step(mk(4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0), C_HALTED, 4'd1, 4'd0, "halt_2");
    step(idle, C_HALTED, 4'd1, 4'd0, "halt_3");
    do_reset("rst_halt");
    step(idle, C_ALL, 4'd0, 4'd0, "post_halt");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
